int_ctrl: RTL and testbench



---
 rtl/int_ctrl_pkg.sv | 23 ++
 rtl/int_gateway.sv | 65 ++++++
 rtl/int_ctrl.sv | 146 ++++++++++++++
 tb/tb_int_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the peripheral interrupt controller: register
// offsets, FSM encoding, ID width and interrupt level constants (the level
// constants are also used by the timer).
package int_ctrl_pkg;

  localparam int unsigned ID_W  = 8;
  localparam int unsigned OFF_W = 4;

  localparam logic [OFF_W-1:0] REG_ENABLE   = 4'h0;
  localparam logic [OFF_W-1:0] REG_PENDING  = 4'h4;
  localparam logic [OFF_W-1:0] REG_CLAIM    = 4'h8;
  localparam logic [OFF_W-1:0] REG_COMPLETE = 4'hC;

  localparam logic INT_ASSERT   = 1'b1;
  localparam logic INT_DEASSERT = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

endpackage

// File: rtl/int_gateway.sv
// Per-source interrupt gateway: pending/in-service bookkeeping for one
// level-sensitive line, with an optional 2-flop input synchroniser.
// Build option: INT_CTRL_SYNC_EN adds the synchroniser (src-to-pending +2 edges).
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   i_src        raw interrupt level
//   i_claim      this source is being claimed this cycle
//   i_complete   this source is being completed this cycle
//   o_pending    pending flag
module int_gateway
  import int_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_src,
  input  logic i_claim,
  input  logic i_complete,
  output logic o_pending
);

  logic w_src;
  logic r_pending;
  logic r_in_service;

`ifdef INT_CTRL_SYNC_EN
  logic r_sync1;
  logic r_sync2;

  // Two-stage synchroniser for asynchronous sources
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_src;
      r_sync2 <= r_sync1;
    end
  end

  assign w_src = r_sync2;
`else
  assign w_src = i_src;
`endif

  // Claim has priority over a simultaneous rise; a dropping level never clears pending
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending    <= 1'b0;
      r_in_service <= 1'b0;
    end else begin
      if (i_claim) begin
        r_pending    <= 1'b0;
        r_in_service <= 1'b1;
      end else if (w_src && !r_pending && !r_in_service) begin
        r_pending <= 1'b1;
      end
      if (i_complete) begin
        r_in_service <= 1'b0;
      end
    end
  end

  assign o_pending = r_pending;

endmodule

// File: rtl/int_ctrl.sv
// Peripheral interrupt controller: gathers level interrupt lines, presents a
// fixed-priority request (lowest index wins) and a claim/complete register
// interface on the 32-bit peripheral bus.
// Build option: INT_CTRL_SYNC_EN synchronises src_i inside each gateway.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   data_i      bus write data
//   addr_i      bus address, [3:0] decoded
//   we_i        bus write enable
//   data_o      bus read data (combinational from addr_i)
//   src_i       level interrupt lines, bit 0 = timer, ID = index + 1
//   int_o       registered interrupt request to the core
//   int_id_o    claimable (ASSERT) or in-service (SERVICE) ID, 0 otherwise
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int unsigned NUM_SRC = 8
)
(
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        data_i,
  input  logic [31:0]        addr_i,
  input  logic               we_i,
  output logic [31:0]        data_o,
  input  logic [NUM_SRC-1:0] src_i,
  output logic               int_o,
  output logic [ID_W-1:0]    int_id_o
);

  logic [NUM_SRC-1:0] r_enable;
  logic [NUM_SRC-1:0] w_pending;
  logic [NUM_SRC-1:0] w_active;
  logic [NUM_SRC-1:0] w_claim_vec;
  logic [NUM_SRC-1:0] w_complete_vec;
  state_t             r_state;
  logic               r_int;
  logic [ID_W-1:0]    r_int_id;
  logic [ID_W-1:0]    w_best_id;
  logic [OFF_W-1:0]   w_off;
  logic               w_enable_wr;
  logic               w_claim_ok;
  logic               w_complete_ok;
  logic               w_unused;

  assign w_off    = addr_i[OFF_W-1:0];
  assign w_active = w_pending & r_enable;
  assign w_unused = ^{addr_i[31:OFF_W], data_i};

  assign w_enable_wr   = we_i && (w_off == REG_ENABLE);
  assign w_claim_ok    = we_i && (w_off == REG_CLAIM) && (r_state != ST_SERVICE)
                         && (w_best_id != '0);
  // In SERVICE r_int_id holds the latched in-service ID
  assign w_complete_ok = we_i && (w_off == REG_COMPLETE) && (r_state == ST_SERVICE)
                         && (data_i[ID_W-1:0] == r_int_id);

  // Fixed priority: descending scan so the lowest active index wins
  always_comb begin
    w_best_id = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (w_active[k]) begin
        w_best_id = ID_W'(k + 1);
      end
    end
  end

  // Register read mux
  always_comb begin
    data_o = '0;
    if (!rst) begin
      case (w_off)
        REG_ENABLE:  data_o = 32'(r_enable);
        REG_PENDING: data_o = 32'(w_pending);
        REG_CLAIM:   data_o = 32'(w_best_id);
        default:     data_o = '0;
      endcase
    end
  end

  // ENABLE register; same-cycle claims see the pre-write value
  always_ff @(posedge clk) begin
    if (rst) begin
      r_enable <= '0;
    end else if (w_enable_wr) begin
      r_enable <= data_i[NUM_SRC-1:0];
    end
  end

  // Per-source gateways
  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    assign w_claim_vec[k]    = w_claim_ok && (w_best_id == ID_W'(k + 1));
    assign w_complete_vec[k] = w_complete_ok && (r_int_id == ID_W'(k + 1));

    int_gateway u_gateway (
      .clk        (clk),
      .rst        (rst),
      .i_src      (src_i[k]),
      .i_claim    (w_claim_vec[k]),
      .i_complete (w_complete_vec[k]),
      .o_pending  (w_pending[k])
    );
  end

  // Request/claim/complete FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_int    <= INT_DEASSERT;
      r_int_id <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_ASSERT: begin
          if (w_claim_ok) begin
            r_state  <= ST_SERVICE;
            r_int    <= INT_DEASSERT;
            r_int_id <= w_best_id;
          end else if (w_active != '0) begin
            r_state  <= ST_ASSERT;
            r_int    <= INT_ASSERT;
            r_int_id <= w_best_id;
          end else begin
            r_state  <= ST_IDLE;
            r_int    <= INT_DEASSERT;
            r_int_id <= '0;
          end
        end
        ST_SERVICE: begin
          if (w_complete_ok) begin
            r_state  <= ST_IDLE;
            r_int    <= INT_DEASSERT;
            r_int_id <= '0;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_int    <= INT_DEASSERT;
          r_int_id <= '0;
        end
      endcase
    end
  end

  assign int_o    = r_int;
  assign int_id_o = r_int_id;

endmodule

// File: tb/tb_int_ctrl.sv
// Directed self-checking bench for int_ctrl (default build, NUM_SRC = 8).
module tb_int_ctrl;

  localparam logic [31:0] A_EN    = 32'h0;
  localparam logic [31:0] A_PEND  = 32'h4;
  localparam logic [31:0] A_CLAIM = 32'h8;
  localparam logic [31:0] A_COMP  = 32'hC;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we_i = 1'b0;
  logic [31:0] data_i = '0;
  logic [31:0] addr_i = '0;
  logic [7:0]  src_i = '0;
  logic [31:0] data_o;
  logic        int_o;
  logic [7:0]  int_id_o;

  int n_vec = 0;
  int n_err = 0;

  int_ctrl #(.NUM_SRC(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .data_i   (data_i),
    .addr_i   (addr_i),
    .we_i     (we_i),
    .data_o   (data_o),
    .src_i    (src_i),
    .int_o    (int_o),
    .int_id_o (int_id_o)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One bus write, captured at the next rising edge; returns at the following negedge
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr_i = a;
    data_i = d;
    we_i   = 1'b1;
    @(negedge clk);
    we_i   = 1'b0;
    data_i = '0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    addr_i = a;
    #1;
    v = data_o;
  endtask

  task automatic test_reset;
    logic [31:0] v;
    step(2);
    addr_i = A_EN; #1;
    n_vec++; if (data_o !== 32'h0) begin n_err++; $display("FAIL rst_data_o: got %h want %h", data_o, 32'h0); end
    n_vec++; if (int_o !== 1'b0) begin n_err++; $display("FAIL rst_int_o: got %b want 0", int_o); end
    n_vec++; if (int_id_o !== 8'h0) begin n_err++; $display("FAIL rst_int_id: got %h want 00", int_id_o); end
    rst = 1'b0;
    step(1);
    rd(A_EN, v);    n_vec++; if (v !== 32'h0) begin n_err++; $display("FAIL rst_enable: got %h want 0", v); end
    rd(A_PEND, v);  n_vec++; if (v !== 32'h0) begin n_err++; $display("FAIL rst_pending: got %h want 0", v); end
    rd(A_CLAIM, v); n_vec++; if (v !== 32'h0) begin n_err++; $display("FAIL rst_claim: got %h want 0", v); end
    rd(A_COMP, v);  n_vec++; if (v !== 32'h0) begin n_err++; $display("FAIL rst_complete: got %h want 0", v); end
  endtask

  task automatic test_basic;
    logic [31:0] v;
    wr(A_EN, 32'h1);
    src_i = 8'h01;
    step(1);
    src_i = 8'h00;
    rd(A_PEND, v); n_vec++; if (v !== 32'h1) begin n_err++; $display("FAIL basic_pending: got %h want 1", v); end
    n_vec++; if (int_o !== 1'b0) begin n_err++; $display("FAIL basic_int_early: got %b want 0", int_o); end
    step(1);
    n_vec++; if (int_o !== 1'b1) begin n_err++; $display("FAIL basic_int_o: got %b want 1", int_o); end
    n_vec++; if (int_id_o !== 8'd1) begin n_err++; $display("FAIL basic_int_id: got %0d want 1", int_id_o); end
    rd(A_CLAIM, v); n_vec++; if (v !== 32'd1) begin n_err++; $display("FAIL basic_claim_rd: got %h want 1", v); end
    wr(A_CLAIM, 32'h0);
    n_vec++; if (int_o !== 1'b0) begin n_err++; $display("FAIL basic_svc_int: got %b want 0", int_o); end
    n_vec++; if (int_id_o !== 8'd1) begin n_err++; $display("FAIL basic_svc_id: got %0d want 1", int_id_o); end
    rd(A_PEND, v); n_vec++; if (v !== 32'h0) begin n_err++; $display("FAIL basic_pend_clr: got %h want 0", v); end
    wr(A_COMP, 32'd1);
    n_vec++; if (int_id_o !== 8'd0) begin n_err++; $display("FAIL basic_done_id: got %0d want 0", int_id_o); end
    step(1);
    n_vec++; if (int_o !== 1'b0) begin n_err++; $display("FAIL basic_idle_int: got %b want 0", int_o); end
  endtask

  task automatic test_priority_rearm;
    logic [31:0] v;
    wr(A_EN, 32'hFF);
    src_i = 8'h0A;
    step(1);
    rd(A_CLAIM, v); n_vec++; if (v !== 32'd2) begin n_err++; $display("FAIL prio_claim_rd: got %h want 2", v); end
    step(1);
    n_vec++; if (int_id_o !== 8'd2) begin n_err++; $display("FAIL prio_int_id: got %0d want 2", int_id_o); end
    wr(A_CLAIM, 32'h0);
    n_vec++; if (int_id_o !== 8'd2) begin n_err++; $display("FAIL prio_svc_id: got %0d want 2", int_id_o); end
    rd(A_PEND, v); n_vec++; if (v !== 32'h08) begin n_err++; $display("FAIL prio_pend_svc: got %h want 08", v); end
    step(1);
    rd(A_PEND, v); n_vec++; if (v !== 32'h08) begin n_err++; $display("FAIL prio_no_repend: got %h want 08", v); end
    wr(A_COMP, 32'd2);
    n_vec++; if (int_o !== 1'b0) begin n_err++; $display("FAIL prio_cmp_int: got %b want 0", int_o); end
    step(1);
    rd(A_PEND, v); n_vec++; if (v !== 32'h0A) begin n_err++; $display("FAIL prio_repend: got %h want 0A", v); end
    n_vec++; if (int_o !== 1'b1) begin n_err++; $display("FAIL prio_reassert: got %b want 1", int_o); end
    n_vec++; if (int_id_o !== 8'd4) begin n_err++; $display("FAIL prio_reassert_id: got %0d want 4", int_id_o); end
    step(1);
    n_vec++; if (int_id_o !== 8'd2) begin n_err++; $display("FAIL prio_track_id: got %0d want 2", int_id_o); end
    src_i = 8'h00;
    wr(A_CLAIM, 32'h0);
    wr(A_COMP, 32'd2);
    wr(A_CLAIM, 32'h0);
    n_vec++; if (int_id_o !== 8'd4) begin n_err++; $display("FAIL prio_svc4_id: got %0d want 4", int_id_o); end
    wr(A_COMP, 32'd4);
    rd(A_PEND, v); n_vec++; if (v !== 32'h0) begin n_err++; $display("FAIL prio_drained: got %h want 0", v); end
  endtask

  task automatic test_complete_mismatch;
    logic [31:0] v;
    src_i = 8'h01;
    step(1);
    src_i = 8'h00;
    step(1);
    wr(A_CLAIM, 32'h0);
    wr(A_COMP, 32'd3);
    n_vec++; if (int_id_o !== 8'd1) begin n_err++; $display("FAIL mis_still_svc: got %0d want 1", int_id_o); end
    src_i = 8'h04;
    step(1);
    src_i = 8'h00;
    wr(A_CLAIM, 32'h0);
    rd(A_PEND, v); n_vec++; if (v !== 32'h04) begin n_err++; $display("FAIL mis_claim_ign_pend: got %h want 04", v); end
    n_vec++; if (int_id_o !== 8'd1) begin n_err++; $display("FAIL mis_claim_ign_id: got %0d want 1", int_id_o); end
    wr(A_COMP, 32'd1);
    n_vec++; if (int_id_o !== 8'd0) begin n_err++; $display("FAIL mis_done_id: got %0d want 0", int_id_o); end
    step(1);
    n_vec++; if (int_id_o !== 8'd3) begin n_err++; $display("FAIL mis_next_id: got %0d want 3", int_id_o); end
    wr(A_CLAIM, 32'h0);
    wr(A_COMP, 32'd3);
  endtask

  task automatic test_enable_gate;
    logic [31:0] v;
    wr(A_EN, 32'h0);
    src_i = 8'h04;
    step(1);
    src_i = 8'h00;
    rd(A_PEND, v); n_vec++; if (v !== 32'h04) begin n_err++; $display("FAIL en_pend: got %h want 04", v); end
    step(2);
    n_vec++; if (int_o !== 1'b0) begin n_err++; $display("FAIL en_masked: got %b want 0", int_o); end
    wr(A_PEND, 32'h0);
    rd(A_PEND, v); n_vec++; if (v !== 32'h04) begin n_err++; $display("FAIL en_pend_ro: got %h want 04", v); end
    wr(A_EN, 32'hFFFF_FF04);
    rd(A_EN, v); n_vec++; if (v !== 32'h04) begin n_err++; $display("FAIL en_readback: got %h want 04", v); end
    rd(32'h2, v); n_vec++; if (v !== 32'h0) begin n_err++; $display("FAIL en_unmapped: got %h want 0", v); end
    step(1);
    n_vec++; if (int_o !== 1'b1) begin n_err++; $display("FAIL en_assert: got %b want 1", int_o); end
    n_vec++; if (int_id_o !== 8'd3) begin n_err++; $display("FAIL en_assert_id: got %0d want 3", int_id_o); end
    wr(A_EN, 32'h0);
    step(1);
    n_vec++; if (int_o !== 1'b0) begin n_err++; $display("FAIL en_deassert: got %b want 0", int_o); end
    n_vec++; if (int_id_o !== 8'd0) begin n_err++; $display("FAIL en_deassert_id: got %0d want 0", int_id_o); end
    wr(A_CLAIM, 32'h0);
    n_vec++; if (int_id_o !== 8'd0) begin n_err++; $display("FAIL en_claim_none: got %0d want 0", int_id_o); end
    rd(A_PEND, v); n_vec++; if (v !== 32'h04) begin n_err++; $display("FAIL en_claim_none_pend: got %h want 04", v); end
    wr(A_EN, 32'h04);
    wr(A_CLAIM, 32'h0);
    wr(A_COMP, 32'd3);
    wr(A_EN, 32'h0);
  endtask

  task automatic test_claim_vs_rise;
    logic [31:0] v;
    wr(A_EN, 32'h1);
    src_i = 8'h01;
    step(1);
    src_i = 8'h00;
    step(1);
    n_vec++; if (int_o !== 1'b1) begin n_err++; $display("FAIL race_assert: got %b want 1", int_o); end
    src_i = 8'h01;
    wr(A_CLAIM, 32'h0);
    rd(A_PEND, v); n_vec++; if (v !== 32'h0) begin n_err++; $display("FAIL race_claim_wins: got %h want 0", v); end
    step(1);
    rd(A_PEND, v); n_vec++; if (v !== 32'h0) begin n_err++; $display("FAIL race_no_repend: got %h want 0", v); end
    n_vec++; if (int_id_o !== 8'd1) begin n_err++; $display("FAIL race_svc_id: got %0d want 1", int_id_o); end
  endtask

  task automatic test_reset_in_service;
    logic [31:0] v;
    rst = 1'b1;
    step(1);
    n_vec++; if (int_o !== 1'b0) begin n_err++; $display("FAIL rsvc_int_o: got %b want 0", int_o); end
    n_vec++; if (int_id_o !== 8'd0) begin n_err++; $display("FAIL rsvc_int_id: got %0d want 0", int_id_o); end
    rd(A_PEND, v); n_vec++; if (v !== 32'h0) begin n_err++; $display("FAIL rsvc_data_in_rst: got %h want 0", v); end
    rst = 1'b0;
    rd(A_EN, v);   n_vec++; if (v !== 32'h0) begin n_err++; $display("FAIL rsvc_enable: got %h want 0", v); end
    rd(A_PEND, v); n_vec++; if (v !== 32'h0) begin n_err++; $display("FAIL rsvc_pend0: got %h want 0", v); end
    step(1);
    rd(A_PEND, v); n_vec++; if (v !== 32'h01) begin n_err++; $display("FAIL rsvc_repend: got %h want 01", v); end
    n_vec++; if (int_o !== 1'b0) begin n_err++; $display("FAIL rsvc_masked: got %b want 0", int_o); end
    src_i = 8'h00;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_priority_rearm;
    test_complete_mismatch;
    test_enable_gate;
    test_claim_vs_rise;
    test_reset_in_service;
    step(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
